// File: rtl/wb_ip_slot_decoder_if.sv
// Purpose: Wishbone bridge-side bus plus per-slot select/ack/data bundle for the IP slot decoder.
// Latency: none (signal bundle only).
// Backpressure: Wishbone ACK handshake; slots stall the bridge by withholding SLOT_ACK_i.
interface wb_ip_slot_decoder_if #(
    parameter int APERWIDTH = 17,
    parameter int NUM_SLOTS = 4
) ();
    logic [APERWIDTH-1:0]   WBs_ADR_i;
    logic                   WBs_CYC_i;
    logic                   WBs_STB_i;
    logic                   WBs_WE_i;
    logic [3:0]             WBs_BYTE_STB_i;
    logic [31:0]            WBs_DAT_i;
    logic [31:0]            WBs_DAT_o;
    logic                   WBs_ACK_o;
    logic [NUM_SLOTS-1:0]   SLOT_CYC_o;
    logic [NUM_SLOTS*32-1:0] SLOT_DAT_i;
    logic [NUM_SLOTS-1:0]   SLOT_ACK_i;

    // Decoder side
    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
        input  SLOT_DAT_i, SLOT_ACK_i,
        output WBs_DAT_o, WBs_ACK_o, SLOT_CYC_o
    );

    // Bridge and slot-model side
    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
        output SLOT_DAT_i, SLOT_ACK_i,
        input  WBs_DAT_o, WBs_ACK_o, SLOT_CYC_o
    );
endinterface

// File: rtl/wb_ip_slot_decoder.sv
// Purpose: decode WBs_ADR into per-slot CYC selects, merge slot ACK/data, bus-timeout watchdog with error capture slot.
// Latency: slot accesses 0 added cycles; status slot 1 cycle; stalled access error-ACKed TIMEOUT_CYCLES after first req.
// Backpressure: slots stall via SLOT_ACK_i; master may abort by dropping CYC/STB. Option: WB_DECODER_FAST_UNMAPPED_EN.
module wb_ip_slot_decoder #(
    parameter int                               APERWIDTH           = 17,
    parameter int                               APERSIZE            = 10,
    parameter int                               NUM_SLOTS           = 4,
    parameter logic [NUM_SLOTS*APERWIDTH-1:0]   SLOT_BASE_ADDR      = {17'h07000, 17'h06000, 17'h05000, 17'h04000},
    parameter logic [APERWIDTH-1:0]             STATUS_BASE_ADDRESS = 17'h1F000,
    parameter logic [31:0]                      DEFAULT_READ_VALUE  = 32'hBADFABAC,
    parameter int                               TIMEOUT_CYCLES      = 16,
    parameter int                               TO_CNTR_WIDTH       = 5
) (
    input  logic                        WBs_CLK_i,
    input  logic                        WBs_RST_i,
    wb_ip_slot_decoder_if.slave         bus,
    output logic                        ERR_INTR_o
);
    localparam int DW = APERWIDTH - APERSIZE;
    localparam logic [TO_CNTR_WIDTH-1:0] TO_LAST = TO_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_CNTR_WIDTH-1:0] TO_MAX  = '1;
    localparam logic [3:0]               NO_SLOT = 4'(NUM_SLOTS);
    localparam logic [APERSIZE-1:0]      OFF_STATUS = APERSIZE'(12'h000);
    localparam logic [APERSIZE-1:0]      OFF_ADDR   = APERSIZE'(12'h004);
    localparam logic [APERSIZE-1:0]      OFF_CTRL   = APERSIZE'(12'h008);
    localparam logic [APERSIZE-1:0]      OFF_ID     = APERSIZE'(12'h00C);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_STAT_ACK, S_ERR_ACK} state_t;

    state_t                     r_state;
    logic [TO_CNTR_WIDTH-1:0]   r_cnt;
    logic [APERWIDTH-1:0]       r_req_adr;
    logic                       r_req_we;
    logic [3:0]                 r_req_slot;
    logic                       r_valid, r_ovf, r_to, r_unm, r_we, r_en, r_intr;
    logic [3:0]                 r_slot;
    logic [APERWIDTH-1:0]       r_addr;

    logic                       w_req, w_stat_hit, w_stat_sel, w_unmapped, w_slot_ack, w_found;
    logic [NUM_SLOTS-1:0]       w_hit;
    logic [3:0]                 w_slot_idx;
    logic [31:0]                w_slot_dat, w_stat_dat;
    logic [APERSIZE-1:0]        w_off;
    logic                       w_stat_wr, w_capture, w_load;
    logic                       w_valid_nxt, w_ovf_nxt, w_en_nxt;
    logic                       w_unused;

    assign w_unused   = ^{bus.WBs_BYTE_STB_i[3:1], bus.WBs_DAT_i[31:2]};
    assign w_req      = bus.WBs_CYC_i & bus.WBs_STB_i;
    assign w_off      = bus.WBs_ADR_i[APERSIZE-1:0];
    assign w_stat_hit = bus.WBs_ADR_i[APERWIDTH-1:APERSIZE] == STATUS_BASE_ADDRESS[APERWIDTH-1:APERSIZE];
    // A slot window overlapping the status window shadows it.
    assign w_stat_sel = w_stat_hit & ~w_found;
    assign w_unmapped = w_req & ~w_found & ~w_stat_hit;
    assign w_slot_ack = |(bus.SLOT_ACK_i & w_hit);

    // Priority address decode (lowest slot wins) with the selected slot's read data
    always_comb begin
        w_hit      = '0;
        w_found    = 1'b0;
        w_slot_idx = NO_SLOT;
        w_slot_dat = DEFAULT_READ_VALUE;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!w_found && bus.WBs_ADR_i[APERWIDTH-1:APERSIZE] ==
                            SLOT_BASE_ADDR[k*APERWIDTH+APERSIZE +: DW]) begin
                w_hit[k]   = 1'b1;
                w_found    = 1'b1;
                w_slot_idx = 4'(k);
                w_slot_dat = bus.SLOT_DAT_i[k*32 +: 32];
            end
        end
    end

    // Local status register read view
    always_comb begin
        case (w_off)
            OFF_STATUS: w_stat_dat = {20'b0, r_slot, 3'b0, r_we, r_unm, r_to, r_ovf, r_valid};
            OFF_ADDR:   w_stat_dat = 32'(r_addr);
            OFF_CTRL:   w_stat_dat = {31'b0, r_en};
            OFF_ID:     w_stat_dat = {8'b0, 16'(TIMEOUT_CYCLES), 8'(NUM_SLOTS)};
            default:    w_stat_dat = DEFAULT_READ_VALUE;
        endcase
    end

    // Bridge-facing outputs; all selects are held off while in reset
    always_comb begin
        bus.SLOT_CYC_o = (WBs_RST_i && r_state != S_ERR_ACK && bus.WBs_CYC_i) ? w_hit : '0;
        bus.WBs_ACK_o  = WBs_RST_i & (w_slot_ack |
                         (w_req & (r_state == S_STAT_ACK || r_state == S_ERR_ACK)));
        if (r_state == S_ERR_ACK || !w_req) bus.WBs_DAT_o = DEFAULT_READ_VALUE;
        else if (w_found)                   bus.WBs_DAT_o = w_slot_dat;
        else if (w_stat_hit)                bus.WBs_DAT_o = w_stat_dat;
        else                                bus.WBs_DAT_o = DEFAULT_READ_VALUE;
    end

    // Next error/control state: w1c and CTRL writes first, then capture overrides
    always_comb begin
        w_stat_wr   = (r_state == S_STAT_ACK) & w_req & w_stat_sel & bus.WBs_WE_i & bus.WBs_BYTE_STB_i[0];
        w_capture   = (r_state == S_ERR_ACK);
        w_valid_nxt = r_valid;
        w_ovf_nxt   = r_ovf;
        w_en_nxt    = r_en;
        w_load      = 1'b0;
        if (w_stat_wr) begin
            if (w_off == OFF_STATUS) begin
                if (bus.WBs_DAT_i[0]) w_valid_nxt = 1'b0;
                if (bus.WBs_DAT_i[1]) w_ovf_nxt   = 1'b0;
            end
            if (w_off == OFF_CTRL) w_en_nxt = bus.WBs_DAT_i[0];
        end
        if (w_capture) begin
            if (w_valid_nxt) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b1;
                w_ovf_nxt   = 1'b0;
                w_load      = 1'b1;
            end
        end
    end

    // Access FSM with saturating watchdog counter and request latch
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_req_adr  <= '0;
            r_req_we   <= 1'b0;
            r_req_slot <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_req_adr  <= bus.WBs_ADR_i;
                        r_req_we   <= bus.WBs_WE_i;
                        r_req_slot <= w_slot_idx;
                        if (w_stat_sel) begin
                            r_state <= S_STAT_ACK;
`ifdef WB_DECODER_FAST_UNMAPPED_EN
                        end else if (w_unmapped) begin
                            r_state <= S_ERR_ACK;
`endif
                        end else if (!w_slot_ack) begin
                            r_state <= S_BUSY;
                            r_cnt   <= TO_CNTR_WIDTH'(1);
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_req || w_slot_ack) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state <= S_ERR_ACK;
                        r_cnt   <= '0;
                    end else if (r_cnt != TO_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Error capture, control and registered interrupt
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_to    <= 1'b0;
            r_unm   <= 1'b0;
            r_we    <= 1'b0;
            r_slot  <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
            r_en    <= w_en_nxt;
            r_intr  <= w_valid_nxt & w_en_nxt;
            if (w_load) begin
                r_unm  <= (r_req_slot == NO_SLOT);
`ifdef WB_DECODER_FAST_UNMAPPED_EN
                r_to   <= (r_req_slot != NO_SLOT);
`else
                r_to   <= 1'b1;
`endif
                r_we   <= r_req_we;
                r_slot <= r_req_slot;
                r_addr <= r_req_adr;
            end
        end
    end

    assign ERR_INTR_o = r_intr;
endmodule
